// File: rtl/snn_ff_pkg.sv
// Shared types and helpers for the forward-forward goodness path.
// Latency: n/a (package only).
// Backpressure: n/a. Optional macro GOODNESS_SQUARE_EN selects squared-activity goodness.
package snn_ff_pkg;

`ifdef GOODNESS_SQUARE_EN
   localparam bit SQUARE_EN = 1'b1;
`else
   localparam bit SQUARE_EN = 1'b0;
`endif

   // default width of the runtime EMA shift
   localparam int GOODNESS_SHIFT_W = 4;

   // width of the per-core mean A: W-1 for linear ReLU, 2(W-1) when squared
   function automatic int mean_width(input int mem_w, input bit square);
      return square ? 2 * (mem_w - 1) : (mem_w - 1);
   endfunction

   // unsigned add clamped to an all-ones value of width w
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
      logic [63:0] sum;
      logic [63:0] lim;
      sum = a + b;
      lim = (64'd1 << w) - 64'd1;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/relu_mean_reduce.sv
// ReLU (optionally squared) of one core's membranes, summed and divided by P into a stage-1 register.
// Latency: 1 edge from valid to a_valid/a.
// Backpressure: none; a new sample is accepted every cycle.
module relu_mean_reduce
   import snn_ff_pkg::*;
#(
   parameter int P  = 8,
   parameter int W  = 13,
   parameter int AW = mean_width(W, SQUARE_EN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid,
   input  logic [P*W-1:0] mem,
   output logic          a_valid,
   output logic [AW-1:0] a
);

   localparam int LP = $clog2(P);
   // per-neuron term has the same width as the mean; the sum adds log2(P) bits
   localparam int RW = AW;
   localparam int SW = RW + LP;

   logic [SW-1:0] sum;
   logic [W-2:0]  r;
   logic [RW-1:0] t;

   // ReLU each neuron, optionally square it, and accumulate at full width
   always_comb begin
      sum = '0;
      r   = '0;
      t   = '0;
      for (int n = 0; n < P; n++) begin
         r = mem[n*W + W - 1] ? '0 : mem[n*W +: W-1];
`ifdef GOODNESS_SQUARE_EN
         t = RW'(r) * RW'(r);
`else
         t = r;
`endif
         sum = sum + SW'(t);
      end
   end

   // stage-1 register: the mean is the sum shifted right by log2(P)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a       <= '0;
      end else begin
         a_valid <= valid;
         if (valid) a <= sum[SW-1:LP];
      end
   end

endmodule

// File: rtl/goodness_ema_engine.sv
// Per-core goodness: stage-1 ReLU mean, stage-2 warm-up load / saturating EMA with threshold flag.
// Latency: 2 edges from core_valid to goodness_bus/goodness_valid/goodness_above.
// Backpressure: none; one sample per core per cycle. GOODNESS_SQUARE_EN selects squared activity.
module goodness_ema_engine
   import snn_ff_pkg::*;
#(
   parameter int CORE_NUM            = 4,
   parameter int POST_NEUR_PARALLEL  = 8,
   parameter int POST_NEUR_MEM_WIDTH = 13,
   parameter int GOODNESS_WIDTH      = 20,
   parameter int SHIFT_WIDTH         = GOODNESS_SHIFT_W
) (
   input  logic                                                   clk,
   input  logic                                                   rst_n,
   input  logic [CORE_NUM-1:0]                                    core_valid,
   input  logic [CORE_NUM-1:0]                                    core_clear_goodness,
   input  logic [CORE_NUM*POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH-1:0] core_mem_bus,
   input  logic [SHIFT_WIDTH-1:0]                                 cfg_avg_shift,
   input  logic [GOODNESS_WIDTH-1:0]                              goodness_threshold,
   output logic [CORE_NUM*GOODNESS_WIDTH-1:0]                     goodness_bus,
   output logic [CORE_NUM-1:0]                                    goodness_valid,
   output logic [CORE_NUM-1:0]                                    goodness_above
);

   localparam int PW = POST_NEUR_PARALLEL * POST_NEUR_MEM_WIDTH;
   localparam int GW = GOODNESS_WIDTH;
   localparam int AW = mean_width(POST_NEUR_MEM_WIDTH, SQUARE_EN);

   for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
      logic          s1_vld;
      logic [AW-1:0] s1_a;
      logic [GW-1:0] a_in;
      logic [GW-1:0] g;
      logic [GW-1:0] g_nxt;
      logic          warm;
      logic          warm_nxt;
      logic          pulse_nxt;
      logic          vld_r;
      logic          above_r;

      relu_mean_reduce #(
         .P  (POST_NEUR_PARALLEL),
         .W  (POST_NEUR_MEM_WIDTH),
         .AW (AW)
      ) u_reduce (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid   (core_valid[c]),
         .mem     (core_mem_bus[c*PW +: PW]),
         .a_valid (s1_vld),
         .a       (s1_a)
      );

      // A enters stage 2 zero-extended, or clamped when it is wider than G
      assign a_in = GW'(sat_add(64'(s1_a), 64'd0, GW));

      // stage-2 rule priority: clear, warm-up load, EMA update, hold
      always_comb begin
         g_nxt     = g;
         warm_nxt  = warm;
         pulse_nxt = 1'b0;
         if (core_clear_goodness[c]) begin
            g_nxt    = '0;
            warm_nxt = 1'b0;
         end else if (s1_vld) begin
            pulse_nxt = 1'b1;
            warm_nxt  = 1'b1;
            if (!warm) g_nxt = a_in;
            else       g_nxt = GW'(sat_add(64'(g - (g >> cfg_avg_shift)),
                                           64'(a_in >> cfg_avg_shift), GW));
         end
      end

      // goodness state and flags; the threshold compares the new G so bus and flag stay coherent
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            g       <= '0;
            warm    <= 1'b0;
            vld_r   <= 1'b0;
            above_r <= 1'b0;
         end else begin
            g       <= g_nxt;
            warm    <= warm_nxt;
            vld_r   <= pulse_nxt;
            above_r <= (g_nxt > goodness_threshold);
         end
      end

      assign goodness_bus[c*GW +: GW] = g;
      assign goodness_valid[c]        = vld_r;
      assign goodness_above[c]        = above_r;
   end

endmodule

// File: tb/tb_goodness_ema_engine.sv
// Self-checking bench for goodness_ema_engine: directed cases plus randomized traffic
// compared every cycle against a per-core arithmetic model of mean, warm-up and EMA.
module tb_goodness_ema_engine;

   localparam int CN = 4;
   localparam int P  = 8;
   localparam int W  = 13;
   localparam int GW = 20;
   localparam int SW = 4;
   localparam longint MAXG = (longint'(1) << GW) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [CN-1:0]       core_valid;
   logic [CN-1:0]       core_clear_goodness;
   logic [CN*P*W-1:0]   core_mem_bus;
   logic [SW-1:0]       cfg_avg_shift;
   logic [GW-1:0]       goodness_threshold;
   logic [CN*GW-1:0]    goodness_bus;
   logic [CN-1:0]       goodness_valid;
   logic [CN-1:0]       goodness_above;

   goodness_ema_engine #(
      .CORE_NUM            (CN),
      .POST_NEUR_PARALLEL  (P),
      .POST_NEUR_MEM_WIDTH (W),
      .GOODNESS_WIDTH      (GW),
      .SHIFT_WIDTH         (SW)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .core_valid          (core_valid),
      .core_clear_goodness (core_clear_goodness),
      .core_mem_bus        (core_mem_bus),
      .cfg_avg_shift       (cfg_avg_shift),
      .goodness_threshold  (goodness_threshold),
      .goodness_bus        (goodness_bus),
      .goodness_valid      (goodness_valid),
      .goodness_above      (goodness_above)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // model state: goodness, warm flag, pending sample, expected flags
   longint mG[CN];
   bit     mwarm[CN];
   bit     s1v[CN];
   longint s1a[CN];
   bit     mpulse[CN];
   bit     mabove[CN];

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic longint dut_g(input int c);
      return longint'(goodness_bus[c*GW +: GW]);
   endfunction

   function automatic longint satg(input longint v);
      return (v > MAXG) ? MAXG : v;
   endfunction

   // mean of ReLU (or squared ReLU) activity of one core, plain integer arithmetic
   function automatic longint calc_a(input int c);
      longint sum = 0;
      for (int n = 0; n < P; n++) begin
         logic signed [W-1:0] m;
         longint r;
         m = core_mem_bus[(c*P + n)*W +: W];
         r = (m < 0) ? 0 : longint'(m);
`ifdef GOODNESS_SQUARE_EN
         r = r * r;
`endif
         sum += r;
      end
      return sum / P;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < CN; c++) begin
         mG[c] = 0; mwarm[c] = 0; s1v[c] = 0; s1a[c] = 0; mpulse[c] = 0; mabove[c] = 0;
      end
   endtask

   // what one clock edge does to each core, from the documented rules
   task automatic model_edge();
      int k;
      k = int'(cfg_avg_shift);
      for (int c = 0; c < CN; c++) begin
         mpulse[c] = 0;
         if (core_clear_goodness[c]) begin
            mG[c] = 0;
            mwarm[c] = 0;
         end else if (s1v[c]) begin
            mpulse[c] = 1;
            if (!mwarm[c]) mG[c] = satg(s1a[c]);
            else           mG[c] = satg(mG[c] - (mG[c] >> k) + (satg(s1a[c]) >> k));
            mwarm[c] = 1;
         end
         mabove[c] = (mG[c] > longint'(goodness_threshold));
         s1v[c] = core_valid[c];
         s1a[c] = calc_a(c);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic set_all(input int c, input int val);
      for (int n = 0; n < P; n++) core_mem_bus[(c*P + n)*W +: W] = W'(val);
   endtask

   task automatic set_rand(input int c);
      for (int n = 0; n < P; n++) core_mem_bus[(c*P + n)*W +: W] = W'($urandom_range(0, 8191));
   endtask

   // one sample on the cores in mask, then inputs idle for the stage-2 edge
   task automatic sample(input logic [CN-1:0] mask, input int val);
      for (int c = 0; c < CN; c++) if (mask[c]) set_all(c, val);
      core_valid = mask;
      tick();
      core_valid = '0;
      tick();
   endtask

   // literal expectation pinned on both the DUT and the model
   task automatic lit(input string name, input int c, input longint exp);
      chk({name, "_dut"}, dut_g(c), exp);
      chk({name, "_model"}, mG[c], exp);
   endtask

   // per-cycle comparison of every core against the model
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         for (int c = 0; c < CN; c++) begin
            chk($sformatf("g_core%0d", c), dut_g(c), mG[c]);
            chk($sformatf("valid_core%0d", c), longint'(goodness_valid[c]), longint'(mpulse[c]));
            chk($sformatf("above_core%0d", c), longint'(goodness_above[c]), longint'(mabove[c]));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pcount;
      core_valid = '0;
      core_clear_goodness = '0;
      core_mem_bus = '0;
      cfg_avg_shift = 4'd4;
      goodness_threshold = 20'd100;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int c = 0; c < CN; c++) chk($sformatf("rst_g%0d", c), dut_g(c), 0);
      chk("rst_valid", longint'(goodness_valid), 0);
      chk("rst_above", longint'(goodness_above), 0);
      rst_n = 1'b1;
      cmp_en = 1'b1;

`ifndef GOODNESS_SQUARE_EN
      // warm-up load
      sample(4'b0001, 100);
      lit("warm_load", 0, 100);
      chk("warm_pulse", longint'(goodness_valid[0]), 1);
      tick();
      chk("pulse_once", longint'(goodness_valid[0]), 0);
      // EMA step: 100 - 6 + 7
      sample(4'b0001, 116);
      lit("ema_step", 0, 101);
      chk("ema_above", longint'(goodness_above[0]), 1);
      // ReLU and mean: four 200s and four -5s give A = 100
      for (int n = 0; n < P; n++) core_mem_bus[n*W +: W] = (n < 4) ? W'(200) : W'(-5);
      core_valid = 4'b0001;
      tick();
      core_valid = '0;
      tick();
      lit("relu_mean", 0, 101);
      sample(4'b0001, -4096);
      lit("decay", 0, 95);
      chk("decay_above", longint'(goodness_above[0]), 0);
      // clear racing a new sample on core 2
      set_all(1, 50); set_all(2, 60); set_all(3, 50);
      sample(4'b1110, 50);
      lit("core1_load", 1, 50);
      set_all(2, 80);
      core_clear_goodness[2] = 1'b1;
      core_valid[2] = 1'b1;
      tick();
      core_clear_goodness = '0;
      core_valid = '0;
      lit("clr_g", 2, 0);
      chk("clr_nopulse", longint'(goodness_valid[2]), 0);
      tick();
      lit("clr_reload", 2, 80);
      chk("clr_reload_pulse", longint'(goodness_valid[2]), 1);
      lit("core0_keep", 0, 95);
      lit("core1_keep", 1, 50);
      lit("core3_keep", 3, 50);
`else
      // squared mean saturates on entry to stage 2
      sample(4'b0001, 4095);
      lit("sq_sat", 0, MAXG);
      core_clear_goodness[0] = 1'b1;
      tick();
      core_clear_goodness = '0;
      lit("sq_clear", 0, 0);
      sample(4'b0001, 10);
      lit("sq_ten", 0, 100);
`endif

      // reset between the two edges of a sample drops it
      set_all(0, 77);
      core_valid = 4'b0001;
      tick();
      core_valid = '0;
      #2;
      rst_n = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
      chk("midrst_g", dut_g(0), 0);
      chk("midrst_valid", longint'(goodness_valid[0]), 0);
      tick();
      chk("midrst_nopulse", longint'(goodness_valid[0]), 0);

      // back-to-back samples every cycle
      pcount = 0;
      for (int i = 0; i < 18; i++) begin
         if (i < 16) begin
            core_valid = 4'b0001;
            set_rand(0);
         end else begin
            core_valid = '0;
         end
         tick();
         if (goodness_valid[0]) pcount++;
      end
      chk("b2b_pulses", pcount, 16);

      // randomized traffic on all cores
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < CN; c++) begin
            core_valid[c] = ($urandom_range(0, 3) != 0);
            core_clear_goodness[c] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) set_all(c, 4095);
            else set_rand(c);
         end
         if ($urandom_range(0, 15) == 0) cfg_avg_shift = SW'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0) goodness_threshold = GW'($urandom_range(0, 5000));
         tick();
      end
      core_valid = '0;
      core_clear_goodness = '0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
